// File: rtl/wb_pkg.sv
// Shared types and helpers for the load-return writeback stage.
// Load funct3 codes, queue entry layout and legality check.
package wb_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam int ENT_SRC_W = 4;
  localparam int ENT_RD_W  = 8;

  typedef struct packed {
    logic [2:0]           funct3;
    logic [1:0]           off;
    logic [ENT_SRC_W-1:0] src;
    logic [ENT_RD_W-1:0]  rd;
  } wb_ld_entry_t;

  function automatic logic ld_illegal(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b1;
    case (funct3)
      FNC_LB, FNC_LBU: bad = 1'b0;
      FNC_LH, FNC_LHU: bad = (off == 2'd3);
      FNC_LW:          bad = (off != 2'd0);
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: shift selected byte/halfword down
// and sign- or zero-extend it to the full word.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] sh;

  assign sh = word >> {off, 3'b000};

  always_comb begin
    value = sh;
    unique case (1'b1)
      funct3 == FNC_LB:
        value = {{(XLEN-8){sh[7]}}, sh[7:0]};
      funct3 == FNC_LH:
        value = {{(XLEN-16){sh[15]}}, sh[15:0]};
      funct3 == FNC_LBU:
        value = {{(XLEN-8){1'b0}}, sh[7:0]};
      funct3 == FNC_LHU:
        value = {{(XLEN-16){1'b0}}, sh[15:0]};
      funct3 == FNC_LW:
        value = sh;
      default:
        value = sh;
    endcase
  end

endmodule

// File: rtl/wb_load_return.sv
// Writeback stage with an in-order queue of outstanding loads,
// per-source response handshake and load-over-ALU arbitration.
module wb_load_return
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4,
  parameter int RA_W    = 5,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [2:0]              issue_funct3,
  input  logic [1:0]              issue_off,
  input  logic [SRC_W-1:0]        issue_src,
  input  logic [RA_W-1:0]         issue_rd,
  input  logic [NUM_SRC-1:0]      rsp_valid,
  input  logic [NUM_SRC*XLEN-1:0] rsp_data,
  output logic [NUM_SRC-1:0]      rsp_ready,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [RA_W-1:0]         alu_rd,
  input  logic [XLEN-1:0]         alu_wdata,
  output logic                    wb_regwen,
  output logic [RA_W-1:0]         wb_rd,
  output logic [XLEN-1:0]         wb_wdata,
  output logic                    misalign_err,
  output logic [(1<<RA_W)-1:0]    pending_rd_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << RA_W;

  wb_ld_entry_t     q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  wb_ld_entry_t     head_ent;
  wb_ld_entry_t     new_ent;
  logic             not_empty;
  logic             head_vld;
  logic             cmp;
  logic             issue_fire;
  logic             illegal;
  logic             push;
  logic             alu_fire;
  logic [XLEN-1:0]  rsp_word;
  logic [XLEN-1:0]  ld_val;
  logic [PTR_W-1:0] rel [DEPTH];

  assign head_ent    = q[head];
  assign not_empty   = (count != '0);
  assign issue_ready = (count < CNT_W'(DEPTH));
  assign issue_fire  = issue_valid && issue_ready;
  assign illegal     = ld_illegal(issue_funct3, issue_off);
  assign push        = issue_fire && !illegal;

  always_comb begin
    new_ent        = '0;
    new_ent.funct3 = issue_funct3;
    new_ent.off    = issue_off;
    new_ent.src    = ENT_SRC_W'(issue_src);
    new_ent.rd     = ENT_RD_W'(issue_rd);
  end

  // Only the head entry's source is steered and acknowledged.
  always_comb begin
    rsp_ready = '0;
    rsp_word  = '0;
    head_vld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (not_empty && head_ent.src == ENT_SRC_W'(i)) begin
        rsp_ready[i] = 1'b1;
        rsp_word     = rsp_data[i*XLEN +: XLEN];
        head_vld     = rsp_valid[i];
      end
    end
  end

  assign cmp       = head_vld;
  assign alu_ready = !cmp;
  assign alu_fire  = alu_valid && alu_ready;

  load_align #(
    .XLEN(XLEN)
  ) u_align (
    .word  (rsp_word),
    .funct3(head_ent.funct3),
    .off   (head_ent.off),
    .value (ld_val)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rel[i] = PTR_W'(i) - head;
    end
  end

  always_comb begin
    pending_rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, rel[i]} < count) begin
        for (int r = 1; r < NREG; r++) begin
          if (q[i].rd == ENT_RD_W'(r)) begin
            pending_rd_mask[r] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (push) begin
        q[tail] <= new_ent;
        tail    <= tail + 1'b1;
      end
      if (cmp) begin
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(cmp);
    end
  end

  // Loads win the write port; rd = 0 still consumes the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_regwen    <= 1'b0;
      wb_rd        <= '0;
      wb_wdata     <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= issue_fire && illegal;
      wb_regwen    <= 1'b0;
      if (cmp) begin
        wb_regwen <= (head_ent.rd != '0);
        wb_rd     <= head_ent.rd[RA_W-1:0];
        wb_wdata  <= ld_val;
      end else if (alu_fire) begin
        wb_regwen <= (alu_rd != '0);
        wb_rd     <= alu_rd;
        wb_wdata  <= alu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_load_return.sv
// Directed bench for wb_load_return: alignment vectors from
// a table, plus queue, arbitration, x0 and reset sequences.
module tb_wb_load_return;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_funct3;
  logic [1:0]  issue_off;
  logic [1:0]  issue_src;
  logic [4:0]  issue_rd;
  logic [2:0]  rsp_valid;
  logic [95:0] rsp_data;
  logic [2:0]  rsp_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        wb_regwen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        misalign_err;
  logic [31:0] pending_rd_mask;

  int n_vec;
  int n_err;

  wb_load_return #(
    .XLEN(32), .NUM_SRC(3), .DEPTH(4), .RA_W(5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_funct3   (issue_funct3),
    .issue_off      (issue_off),
    .issue_src      (issue_src),
    .issue_rd       (issue_rd),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_wdata      (alu_wdata),
    .wb_regwen      (wb_regwen),
    .wb_rd          (wb_rd),
    .wb_wdata       (wb_wdata),
    .misalign_err   (misalign_err),
    .pending_rd_mask(pending_rd_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    int          src;
    logic [4:0]  rd;
    logic [31:0] word;
    logic        err;
    logic [31:0] exp;
  } vec_t;

  vec_t v [11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [1:0] off,
                       input int src, input logic [4:0] rd);
    issue_funct3 = f3;
    issue_off    = off;
    issue_src    = 2'(src);
    issue_rd     = rd;
    issue_valid  = 1'b1;
    #1;
    chk("issue_ready", {31'b0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic set_rsp(input int src, input logic [31:0] w);
    rsp_data = {3{32'hA5A5_A5A5}};
    rsp_data[src*32 +: 32] = w;
    rsp_valid = 3'(1 << src);
  endtask

  initial begin
    int srcs [4];
    logic [31:0] em;
    n_vec = 0;
    n_err = 0;

    v[0]  = '{3'b000, 2'd2, 1, 5'd5,  32'h1280_3456, 1'b0, 32'hFFFF_FF80};
    v[1]  = '{3'b101, 2'd2, 1, 5'd6,  32'hBEEF_0000, 1'b0, 32'h0000_BEEF};
    v[2]  = '{3'b001, 2'd3, 1, 5'd6,  32'h0,         1'b1, 32'h0};
    v[3]  = '{3'b010, 2'd0, 0, 5'd10, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    v[4]  = '{3'b100, 2'd3, 2, 5'd31, 32'h9A00_0000, 1'b0, 32'h0000_009A};
    v[5]  = '{3'b001, 2'd0, 2, 5'd1,  32'h0001_8001, 1'b0, 32'hFFFF_8001};
    v[6]  = '{3'b000, 2'd1, 0, 5'd0,  32'h0000_7F00, 1'b0, 32'h0000_007F};
    v[7]  = '{3'b010, 2'd2, 0, 5'd3,  32'h0,         1'b1, 32'h0};
    v[8]  = '{3'b011, 2'd0, 0, 5'd3,  32'h0,         1'b1, 32'h0};
    v[9]  = '{3'b100, 2'd0, 1, 5'd9,  32'h0000_00FF, 1'b0, 32'h0000_00FF};
    v[10] = '{3'b001, 2'd1, 0, 5'd12, 32'h00AB_CD00, 1'b0, 32'hFFFF_ABCD};

    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_funct3 = '0;
    issue_off = '0;
    issue_src = '0;
    issue_rd = '0;
    rsp_valid = 3'b111;
    rsp_data = '0;
    alu_valid = 1'b0;
    alu_rd = '0;
    alu_wdata = '0;
    step();
    step();
    chk("rst_regwen", {31'b0, wb_regwen}, 32'd0);
    chk("rst_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_rsp_ready", {29'b0, rsp_ready}, 32'd0);
    chk("rst_mask", pending_rd_mask, 32'd0);
    chk("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
    rsp_valid = '0;
    rst_n = 1'b1;
    step();

    // Alignment / legality table
    for (int k = 0; k < 11; k++) begin
      issue(v[k].f3, v[k].off, v[k].src, v[k].rd);
      chk("misalign", {31'b0, misalign_err}, {31'b0, v[k].err});
      if (v[k].err) begin
        chk("ill_mask", pending_rd_mask, 32'd0);
        chk("ill_rsp_ready", {29'b0, rsp_ready}, 32'd0);
        step();
        chk("err_pulse", {31'b0, misalign_err}, 32'd0);
        chk("ill_nowrite", {31'b0, wb_regwen}, 32'd0);
      end else begin
        em = (v[k].rd != 0) ? (32'h1 << v[k].rd) : 32'h0;
        chk("pend_mask", pending_rd_mask, em);
        chk("rsp_ready", {29'b0, rsp_ready}, 32'h1 << v[k].src);
        set_rsp(v[k].src, v[k].word);
        #1;
        chk("alu_blocked", {31'b0, alu_ready}, 32'd0);
        step();
        rsp_valid = '0;
        chk("ld_regwen", {31'b0, wb_regwen}, {31'b0, v[k].rd != 0});
        chk("ld_rd", {27'b0, wb_rd}, {27'b0, v[k].rd});
        chk("ld_wdata", wb_wdata, v[k].exp);
        chk("mask_clr", pending_rd_mask, 32'd0);
      end
    end

    // Full queue, foreign response ignored, in-order completions
    srcs = '{0, 1, 2, 1};
    for (int k = 0; k < 4; k++) begin
      issue(3'b010, 2'd0, srcs[k], 5'(k + 1));
    end
    chk("full_ready", {31'b0, issue_ready}, 32'd0);
    chk("full_mask", pending_rd_mask, 32'h0000_001E);
    set_rsp(2, 32'hEEEE_EEEE);
    #1;
    chk("foreign_rsp_ready", {29'b0, rsp_ready}, 32'b001);
    chk("foreign_alu_ready", {31'b0, alu_ready}, 32'd1);
    step();
    chk("foreign_nowrite", {31'b0, wb_regwen}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        rsp_data[s*32 +: 32] = 32'h1000 * (k + 1) + s;
      end
      rsp_valid = 3'b111;
      if (k == 0) begin
        issue_funct3 = 3'b010;
        issue_off = 2'd0;
        issue_src = 2'd0;
        issue_rd = 5'd20;
        issue_valid = 1'b1;
        #1;
        chk("full_pop_ready", {31'b0, issue_ready}, 32'd0);
      end
      step();
      issue_valid = 1'b0;
      chk("order_rd", {27'b0, wb_rd}, 32'(k + 1));
      chk("order_wdata", wb_wdata, 32'h1000 * (k + 1) + srcs[k]);
      chk("order_regwen", {31'b0, wb_regwen}, 32'd1);
    end
    rsp_valid = '0;
    step();
    chk("drain_regwen", {31'b0, wb_regwen}, 32'd0);
    chk("drain_mask", pending_rd_mask, 32'd0);
    chk("drain_ready", {31'b0, issue_ready}, 32'd1);

    // Load beats ALU in the same cycle
    issue(3'b010, 2'd0, 1, 5'd8);
    set_rsp(1, 32'h0000_0055);
    alu_valid = 1'b1;
    alu_rd = 5'd7;
    alu_wdata = 32'h0000_00A5;
    #1;
    chk("arb_alu_ready", {31'b0, alu_ready}, 32'd0);
    step();
    rsp_valid = '0;
    chk("arb_ld_rd", {27'b0, wb_rd}, 32'd8);
    chk("arb_ld_wdata", wb_wdata, 32'h55);
    #1;
    chk("arb_alu_ready2", {31'b0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("arb_alu_rd", {27'b0, wb_rd}, 32'd7);
    chk("arb_alu_wdata", wb_wdata, 32'hA5);
    chk("arb_alu_regwen", {31'b0, wb_regwen}, 32'd1);
    step();
    chk("idle_regwen", {31'b0, wb_regwen}, 32'd0);
    chk("idle_hold_rd", {27'b0, wb_rd}, 32'd7);

    // Issue and completion in the same cycle
    issue(3'b010, 2'd0, 0, 5'd11);
    issue_funct3 = 3'b010;
    issue_off = 2'd0;
    issue_src = 2'd1;
    issue_rd = 5'd12;
    issue_valid = 1'b1;
    set_rsp(0, 32'h0000_0B0B);
    step();
    issue_valid = 1'b0;
    rsp_valid = '0;
    chk("sim_rd", {27'b0, wb_rd}, 32'd11);
    chk("sim_mask", pending_rd_mask, 32'h0000_1000);
    set_rsp(1, 32'h0000_0C0C);
    step();
    rsp_valid = '0;
    chk("sim_rd2", {27'b0, wb_rd}, 32'd12);
    chk("sim_wdata2", wb_wdata, 32'h0C0C);

    // ALU to x0 is consumed without a write
    alu_valid = 1'b1;
    alu_rd = 5'd0;
    alu_wdata = 32'h33;
    #1;
    chk("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    chk("x0_alu_regwen", {31'b0, wb_regwen}, 32'd0);

    // Reset with loads in flight
    for (int k = 0; k < 3; k++) begin
      issue(3'b010, 2'd0, 0, 5'(13 + k));
    end
    chk("pre_rst_mask", pending_rd_mask, 32'h0000_E000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regwen", {31'b0, wb_regwen}, 32'd0);
    chk("mid_rst_wdata", wb_wdata, 32'd0);
    chk("mid_rst_rsp_ready", {29'b0, rsp_ready}, 32'd0);
    chk("mid_rst_mask", pending_rd_mask, 32'd0);
    chk("mid_rst_alu_ready", {31'b0, alu_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, issue_ready}, 32'd1);
    rsp_valid = 3'b111;
    #1;
    chk("post_rst_rsp_ready", {29'b0, rsp_ready}, 32'd0);
    step();
    rsp_valid = '0;
    chk("post_rst_nowrite", {31'b0, wb_regwen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
